// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared types for the reservation-station issue queue.
//   TAG_WIDTH      physical register tag width
//   PAYLOAD_WIDTH  opaque uop payload width (carried untouched)
//   rs_entry_t     per-entry source/destination tags, ready bits and payload
//   tag_match      one CDB port against one source tag
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam int TAG_WIDTH     = 6;
  localparam int PAYLOAD_WIDTH = 32;

  // Valid bit and age key live in their own arrays in the queue so that
  // the key width can follow the queue depth parameter.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]     src1_tag;
    logic                     src1_rdy;
    logic [TAG_WIDTH-1:0]     src2_tag;
    logic                     src2_rdy;
    logic [TAG_WIDTH-1:0]     dst_tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } rs_entry_t;

  // A broadcast only wakes a source when the port is actually driving a tag.
  function automatic logic tag_match(input logic                 bus_valid,
                                     input logic [TAG_WIDTH-1:0] bus_tag,
                                     input logic [TAG_WIDTH-1:0] src_tag);
    return bus_valid && (bus_tag == src_tag);
  endfunction

endpackage

// File: rtl/sort.sv
// ---------------------------------------------------------------------------
// sort
// Combinational min-select tree. Among all requesting inputs, grants the one
// whose data is smallest.
//   i_req   per-input request
//   i_data  per-input sort key
//   o_gnt   one-hot grant of the minimum-key requester (zero when none)
//   o_data  key of the granted requester
// ---------------------------------------------------------------------------
module sort #(
  parameter int REQ_NUM    = 16,
  parameter int DATA_WIDTH = 4
) (
  input  logic [REQ_NUM-1:0]                 i_req,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0] i_data,
  output logic [REQ_NUM-1:0]                 o_gnt,
  output logic [DATA_WIDTH-1:0]              o_data
);

  localparam int NODES = 2 * REQ_NUM - 1;
  localparam int IW    = $clog2(REQ_NUM);

  logic [NODES-1:0]      node_vld;
  logic [DATA_WIDTH-1:0] node_data [NODES];
  logic [IW-1:0]         node_idx  [NODES];

  // Heap-ordered binary tree: leaves sit at REQ_NUM-1.., each inner node keeps
  // the smaller of its two valid children. Keys in the queue are distinct, so
  // the left-wins tie-break never actually decides anything.
  always_comb begin
    node_vld = '0;
    for (int n = 0; n < NODES; n++) begin
      node_data[n] = '0;
      node_idx[n]  = '0;
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      node_vld[REQ_NUM-1+i]  = i_req[i];
      node_data[REQ_NUM-1+i] = i_data[i];
      node_idx[REQ_NUM-1+i]  = IW'(i);
    end
    for (int n = REQ_NUM - 2; n >= 0; n--) begin
      if (node_vld[2*n+1] &&
          (!node_vld[2*n+2] || (node_data[2*n+1] <= node_data[2*n+2]))) begin
        node_data[n] = node_data[2*n+1];
        node_idx[n]  = node_idx[2*n+1];
      end else begin
        node_data[n] = node_data[2*n+2];
        node_idx[n]  = node_idx[2*n+2];
      end
      node_vld[n] = node_vld[2*n+1] | node_vld[2*n+2];
    end
    o_gnt = '0;
    if (node_vld[0]) begin
      o_gnt[node_idx[0]] = 1'b1;
    end
    o_data = node_data[0];
  end

endmodule

// File: rtl/rs_issue_queue.sv
// ---------------------------------------------------------------------------
// rs_issue_queue
// Age-ordered reservation station for one functional-unit port. Holds uops
// until both sources are woken by the CDB, picks the oldest ready entry and
// presents it on a registered valid/ready issue port.
//   clock / reset / flush             clocking, async reset, sync squash
//   dispatch_*                        incoming uop and handshake
//   cdb_valid / cdb_tag               CDB_NUM wakeup broadcasts per cycle
//   issue_*                           registered issue port toward the FU
//   occupancy                         number of valid entries
// ---------------------------------------------------------------------------
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int CDB_NUM  = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [TAG_WIDTH-1:0]          dispatch_src1_tag,
  input  logic                          dispatch_src1_rdy,
  input  logic [TAG_WIDTH-1:0]          dispatch_src2_tag,
  input  logic                          dispatch_src2_rdy,
  input  logic [TAG_WIDTH-1:0]          dispatch_dst_tag,
  input  logic [PAYLOAD_WIDTH-1:0]      dispatch_payload,
  input  logic [CDB_NUM-1:0]            cdb_valid,
  input  logic [CDB_NUM*TAG_WIDTH-1:0]  cdb_tag,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [TAG_WIDTH-1:0]          issue_src1_tag,
  output logic [TAG_WIDTH-1:0]          issue_src2_tag,
  output logic [TAG_WIDTH-1:0]          issue_dst_tag,
  output logic [PAYLOAD_WIDTH-1:0]      issue_payload,
  output logic [$clog2(RS_DEPTH):0]     occupancy
);

  localparam int KW = $clog2(RS_DEPTH);
  localparam int CW = KW + 1;

  logic [RS_DEPTH-1:0]         valid_q, valid_d;
  rs_entry_t                   entry_q [RS_DEPTH];
  rs_entry_t                   entry_d [RS_DEPTH];
  logic [RS_DEPTH-1:0][KW-1:0] key_q, key_d;
  logic                        issue_valid_q, issue_valid_d;
  rs_entry_t                   issue_q, issue_d;

  logic [RS_DEPTH-1:0] req;
  logic [RS_DEPTH-1:0] gnt;
  logic [KW-1:0]       gnt_key;
  logic [CW-1:0]       count;
  logic [KW-1:0]       alloc_idx;
  logic                load;
  logic                accept;
  logic                disp_hit1;
  logic                disp_hit2;

  // Occupancy, the free-slot priority encoder and the select requests all
  // come from registered state only, which keeps issue_ready out of the
  // dispatch_ready cone.
  always_comb begin
    count     = '0;
    alloc_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      count  = count + CW'(valid_q[i]);
      req[i] = valid_q[i] && entry_q[i].src1_rdy && entry_q[i].src2_rdy;
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_idx = KW'(i);
      end
    end
  end

  assign occupancy      = count;
  assign dispatch_ready = (count < CW'(RS_DEPTH));

  // The key of the granted entry comes straight out of the tree and drives
  // the renumbering of younger entries.
  sort #(
    .REQ_NUM    (RS_DEPTH),
    .DATA_WIDTH (KW)
  ) u_sort (
    .i_req  (req),
    .i_data (key_q),
    .o_gnt  (gnt),
    .o_data (gnt_key)
  );

  // Next state: wakeup, free of the granted entry with key compaction,
  // dispatch with CDB bypass, issue register load/drain, then flush on top.
  always_comb begin
    valid_d       = valid_q;
    entry_d       = entry_q;
    key_d         = key_q;
    issue_valid_d = issue_valid_q;
    issue_d       = issue_q;
    disp_hit1     = 1'b0;
    disp_hit2     = 1'b0;

    load   = (|gnt) && (!issue_valid_q || issue_ready);
    accept = dispatch_valid && dispatch_ready && !flush;

    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = 0; k < CDB_NUM; k++) begin
        if (tag_match(cdb_valid[k], cdb_tag[k*TAG_WIDTH +: TAG_WIDTH], entry_q[i].src1_tag)) begin
          entry_d[i].src1_rdy = 1'b1;
        end
        if (tag_match(cdb_valid[k], cdb_tag[k*TAG_WIDTH +: TAG_WIDTH], entry_q[i].src2_tag)) begin
          entry_d[i].src2_rdy = 1'b1;
        end
      end
      if (load && gnt[i]) begin
        valid_d[i] = 1'b0;
      end else if (load && valid_q[i] && (key_q[i] > gnt_key)) begin
        key_d[i] = key_q[i] - 1'b1;
      end
    end

    if (load) begin
      issue_valid_d = 1'b1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (gnt[i]) begin
          issue_d = entry_q[i];
        end
      end
    end else if (issue_ready) begin
      issue_valid_d = 1'b0;
    end

    for (int k = 0; k < CDB_NUM; k++) begin
      disp_hit1 = disp_hit1 | tag_match(cdb_valid[k], cdb_tag[k*TAG_WIDTH +: TAG_WIDTH], dispatch_src1_tag);
      disp_hit2 = disp_hit2 | tag_match(cdb_valid[k], cdb_tag[k*TAG_WIDTH +: TAG_WIDTH], dispatch_src2_tag);
    end

    // The new uop is the youngest; if another entry leaves this edge the
    // count it would have been appended after shrinks by one.
    if (accept) begin
      valid_d[alloc_idx]          = 1'b1;
      entry_d[alloc_idx].src1_tag = dispatch_src1_tag;
      entry_d[alloc_idx].src1_rdy = dispatch_src1_rdy | disp_hit1;
      entry_d[alloc_idx].src2_tag = dispatch_src2_tag;
      entry_d[alloc_idx].src2_rdy = dispatch_src2_rdy | disp_hit2;
      entry_d[alloc_idx].dst_tag  = dispatch_dst_tag;
      entry_d[alloc_idx].payload  = dispatch_payload;
      key_d[alloc_idx]            = KW'(count) - KW'(load);
    end

    if (flush) begin
      valid_d       = '0;
      issue_valid_d = 1'b0;
    end
  end

  // State registers; reset empties the queue and zeroes the issue port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      key_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      key_q         <= key_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign issue_valid    = issue_valid_q;
  assign issue_src1_tag = issue_q.src1_tag;
  assign issue_src2_tag = issue_q.src2_tag;
  assign issue_dst_tag  = issue_q.dst_tag;
  assign issue_payload  = issue_q.payload;

endmodule

// File: tb/tb_rs_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_rs_issue_queue
// Self-checking bench for rs_issue_queue. A queue-based age model tracks
// which uops are waiting and which one must be on the issue port.
// ---------------------------------------------------------------------------
module tb_rs_issue_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  dispatch_src1_tag;
  logic        dispatch_src1_rdy;
  logic [5:0]  dispatch_src2_tag;
  logic        dispatch_src2_rdy;
  logic [5:0]  dispatch_dst_tag;
  logic [31:0] dispatch_payload;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_src1_tag;
  logic [5:0]  issue_src2_tag;
  logic [5:0]  issue_dst_tag;
  logic [31:0] issue_payload;
  logic [4:0]  occupancy;

  int errors    = 0;
  int checks    = 0;
  int dispCount = 0;
  bit checkEn   = 1'b0;

  rs_issue_queue dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_src1_tag (dispatch_src1_tag),
    .dispatch_src1_rdy (dispatch_src1_rdy),
    .dispatch_src2_tag (dispatch_src2_tag),
    .dispatch_src2_rdy (dispatch_src2_rdy),
    .dispatch_dst_tag  (dispatch_dst_tag),
    .dispatch_payload  (dispatch_payload),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_src1_tag    (issue_src1_tag),
    .issue_src2_tag    (issue_src2_tag),
    .issue_dst_tag     (issue_dst_tag),
    .issue_payload     (issue_payload),
    .occupancy         (occupancy)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  s1t;
    logic        s1r;
    logic [5:0]  s2t;
    logic        s2r;
    logic [5:0]  dst;
    logic [31:0] pl;
  } mentry_t;

  // Model state: waiting uops oldest-first, plus the issue port contents.
  mentry_t mq[$];
  bit      miv;
  mentry_t mis;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cdbHit(input logic [5:0] t);
    for (int k = 0; k < 3; k++) begin
      if (cdb_valid[k] && (cdb_tag[k*6 +: 6] == t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural model: oldest ready uop moves to the issue port when it is
  // free or being drained, then CDB wakeups apply, then a dispatch appends.
  always @(posedge clock or posedge reset) begin : model
    int      sel;
    bit      canDisp;
    mentry_t e;
    if (reset) begin
      mq.delete();
      miv = 1'b0;
    end else if (flush) begin
      mq.delete();
      miv = 1'b0;
    end else begin
      sel     = -1;
      canDisp = (mq.size() < 16);
      for (int i = 0; i < mq.size(); i++) begin
        if (sel < 0 && mq[i].s1r && mq[i].s2r) sel = i;
      end
      if (sel >= 0 && (!miv || issue_ready)) begin
        miv = 1'b1;
        mis = mq[sel];
        mq.delete(sel);
      end else if (issue_ready) begin
        miv = 1'b0;
      end
      foreach (mq[i]) begin
        if (cdbHit(mq[i].s1t)) mq[i].s1r = 1'b1;
        if (cdbHit(mq[i].s2t)) mq[i].s2r = 1'b1;
      end
      if (dispatch_valid && canDisp) begin
        e.s1t = dispatch_src1_tag;
        e.s1r = dispatch_src1_rdy | cdbHit(dispatch_src1_tag);
        e.s2t = dispatch_src2_tag;
        e.s2r = dispatch_src2_rdy | cdbHit(dispatch_src2_tag);
        e.dst = dispatch_dst_tag;
        e.pl  = dispatch_payload;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clock) begin
    if (checkEn && !reset) begin
      checkOutput("cmp_occupancy", 64'(occupancy), 64'(mq.size()));
      checkOutput("cmp_dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < 16));
      checkOutput("cmp_issue_valid", 64'(issue_valid), 64'(miv));
      if (miv) begin
        checkOutput("cmp_issue_src1", 64'(issue_src1_tag), 64'(mis.s1t));
        checkOutput("cmp_issue_src2", 64'(issue_src2_tag), 64'(mis.s2t));
        checkOutput("cmp_issue_dst", 64'(issue_dst_tag), 64'(mis.dst));
        checkOutput("cmp_issue_payload", 64'(issue_payload), 64'(mis.pl));
      end
    end
  end

  // Drive one cycle of inputs at a falling edge and wait for the next one.
  task automatic applyStimulus(input bit dv, input logic [5:0] s1t, input bit s1r,
                               input logic [5:0] s2t, input bit s2r, input logic [5:0] dst,
                               input logic [2:0] cv, input logic [17:0] ct,
                               input bit ir, input bit fl);
    dispatch_valid    = dv;
    dispatch_src1_tag = s1t;
    dispatch_src1_rdy = s1r;
    dispatch_src2_tag = s2t;
    dispatch_src2_rdy = s2r;
    dispatch_dst_tag  = dst;
    dispatch_payload  = {8'hA5, 18'(dispCount), dst};
    cdb_valid         = cv;
    cdb_tag           = ct;
    issue_ready       = ir;
    flush             = fl;
    dispCount++;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 18'd0, ir, 0);
  endtask

  function automatic logic [17:0] cdbTags(input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
    return {p2, p1, p0};
  endfunction

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    dispatch_valid = 1'b0; dispatch_src1_tag = '0; dispatch_src1_rdy = 1'b0;
    dispatch_src2_tag = '0; dispatch_src2_rdy = 1'b0; dispatch_dst_tag = '0;
    dispatch_payload = '0; cdb_valid = '0; cdb_tag = '0; issue_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("rst_dispatch_ready", 64'(dispatch_ready), 64'd1);
    checkOutput("rst_issue_dst", 64'(issue_dst_tag), 64'd0);
    checkOutput("rst_issue_payload", 64'(issue_payload), 64'd0);
    checkEn = 1'b1;

    $display("[TB] wakeup vs ready-at-dispatch ordering");
    applyStimulus(1, 6'd3, 0, 6'd4, 0, 6'd10, 3'b000, 18'd0, 1, 0);
    applyStimulus(1, 6'd1, 1, 6'd2, 1, 6'd11, 3'b000, 18'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b101, cdbTags(6'd3, 6'd0, 6'd4), 1, 0);
    checkOutput("t2_first_dst", 64'(issue_dst_tag), 64'd11);
    checkOutput("t2_occ_after_first", 64'(occupancy), 64'd1);
    idle(1, 1);
    checkOutput("t2_second_dst", 64'(issue_dst_tag), 64'd10);
    checkOutput("t2_second_valid", 64'(issue_valid), 64'd1);
    idle(1, 1);
    checkOutput("t2_drained", 64'(issue_valid), 64'd0);

    $display("[TB] age order independent of slot index");
    applyStimulus(1, 6'd24, 0, 6'd24, 0, 6'd34, 3'b000, 18'd0, 1, 0);
    applyStimulus(1, 6'd21, 0, 6'd21, 0, 6'd31, 3'b000, 18'd0, 1, 0);
    applyStimulus(1, 6'd22, 0, 6'd22, 0, 6'd32, 3'b000, 18'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b010, cdbTags(6'd0, 6'd24, 6'd0), 1, 0);
    idle(1, 1);
    checkOutput("t3_first_dst", 64'(issue_dst_tag), 64'd34);
    applyStimulus(1, 6'd23, 0, 6'd23, 0, 6'd33, 3'b000, 18'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b011, cdbTags(6'd21, 6'd23, 6'd0), 1, 0);
    idle(1, 1);
    checkOutput("t3_older_dst", 64'(issue_dst_tag), 64'd31);
    idle(1, 1);
    checkOutput("t3_younger_dst", 64'(issue_dst_tag), 64'd33);
    checkOutput("t3_occ", 64'(occupancy), 64'd1);
    idle(1, 1);

    $display("[TB] full queue and issue stall");
    applyStimulus(1, 6'd61, 0, 6'd61, 0, 6'd61, 3'b000, 18'd0, 1, 0);
    for (int i = 0; i < 14; i++) applyStimulus(1, 6'd62, 0, 6'd62, 0, 6'(40 + i), 3'b000, 18'd0, 1, 0);
    checkOutput("t4_full_occ", 64'(occupancy), 64'd16);
    checkOutput("t4_full_ready", 64'(dispatch_ready), 64'd0);
    applyStimulus(1, 6'd1, 1, 6'd1, 1, 6'd5, 3'b000, 18'd0, 1, 0);
    checkOutput("t4_drop_occ", 64'(occupancy), 64'd16);
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b101, cdbTags(6'd22, 6'd0, 6'd61), 0, 0);
    idle(1, 0);
    checkOutput("t4_stall_load_dst", 64'(issue_dst_tag), 64'd32);
    for (int i = 0; i < 3; i++) begin
      idle(1, 0);
      checkOutput("t4_stall_dst", 64'(issue_dst_tag), 64'd32);
      checkOutput("t4_stall_occ", 64'(occupancy), 64'd15);
    end
    idle(1, 1);
    checkOutput("t4_next_dst", 64'(issue_dst_tag), 64'd61);
    idle(1, 1);

    $display("[TB] dispatch bypass");
    applyStimulus(1, 6'd9, 0, 6'd5, 1, 6'd9, 3'b010, cdbTags(6'd0, 6'd9, 6'd0), 1, 0);
    checkOutput("t5_not_yet", 64'(issue_valid), 64'd0);
    idle(1, 1);
    checkOutput("t5_issued_valid", 64'(issue_valid), 64'd1);
    checkOutput("t5_issued_dst", 64'(issue_dst_tag), 64'd9);
    idle(1, 1);

    $display("[TB] reset mid-run");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t1_occ", 64'(occupancy), 64'd0);
    checkOutput("t1_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("t1_dispatch_ready", 64'(dispatch_ready), 64'd1);

    $display("[TB] flush");
    applyStimulus(1, 6'd1, 1, 6'd1, 1, 6'd7, 3'b000, 18'd0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 6'd50, 0, 6'd50, 0, 6'(12 + i), 3'b000, 18'd0, 0, 0);
    checkOutput("t6_pre_occ", 64'(occupancy), 64'd4);
    checkOutput("t6_pre_dst", 64'(issue_dst_tag), 64'd7);
    applyStimulus(1, 6'd2, 1, 6'd2, 1, 6'd8, 3'b000, 18'd0, 0, 1);
    checkOutput("t6_occ", 64'(occupancy), 64'd0);
    checkOutput("t6_issue_valid", 64'(issue_valid), 64'd0);
    idle(1, 1);
    checkOutput("t6_dropped", 64'(occupancy), 64'd0);

    $display("[TB] mixed traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus((i % 4) != 3, 6'((i * 5) % 64), (i % 5) == 0, 6'((i * 11) % 64), (i % 3) == 0,
                    6'(i), 3'(i % 8), cdbTags(6'((i * 7) % 64), 6'((i * 13 + 5) % 64), 6'((i * 3 + 1) % 64)),
                    (i % 3) != 0, i == 45);
    end
    idle(20, 1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
